// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the LED-matrix frame capture block.
package matrix_pkg;
   localparam int MATRIX_COLS = 16;
   localparam int MATRIX_ROWS = 16;
   localparam int FRAME_BITS  = MATRIX_COLS * MATRIX_ROWS;
   localparam int COL_BITS    = $clog2(MATRIX_COLS);

   typedef enum logic {
      SYNC    = 1'b0,
      CAPTURE = 1'b1
   } state_t;
endpackage

// File: rtl/matrix_frame_capture_if.sv
// Column-scan stream into the capture block and the rebuilt frame/status out of it.
interface matrix_frame_capture_if;
   import matrix_pkg::*;

   logic [MATRIX_ROWS-1:0] data_col;
   logic [COL_BITS-1:0]    curr_col;
   logic [FRAME_BITS-1:0]  frame;
   logic                   frame_valid;
   logic                   seq_error;
   logic                   locked;
   logic [7:0]             frame_count;

   modport master (
      output data_col, curr_col,
      input  frame, frame_valid, seq_error, locked, frame_count
   );

   modport slave (
      input  data_col, curr_col,
      output frame, frame_valid, seq_error, locked, frame_count
   );
endinterface

// File: rtl/scan_stability_det.sv
// Emits one sample pulse per column dwell once column index and data have been
// unchanged for STABLE_CYCLES consecutive edges.
module scan_stability_det
   import matrix_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [COL_BITS-1:0]    curr_col,
   input  logic [MATRIX_ROWS-1:0] data_col,
   output logic                   sample_pulse,
   output logic [COL_BITS-1:0]    sample_col,
   output logic [MATRIX_ROWS-1:0] sample_data
);
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
   localparam logic [7:0] CNT_HIT = 8'(STABLE_CYCLES - 1);

   logic [COL_BITS-1:0]    prev_col_reg;
   logic [MATRIX_ROWS-1:0] prev_data_reg;
   logic [7:0]             cnt_reg;
   logic                   sampled_reg;
   logic                   same;

   assign same         = (curr_col == prev_col_reg) && (data_col == prev_data_reg);
   assign sample_pulse = same && (cnt_reg == CNT_HIT) && !sampled_reg;
   assign sample_col   = prev_col_reg;
   assign sample_data  = prev_data_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_col_reg  <= '0;
         prev_data_reg <= '0;
         cnt_reg       <= '0;
         sampled_reg   <= 1'b0;
      end else begin
         prev_col_reg  <= curr_col;
         prev_data_reg <= data_col;
         if (!same)
            cnt_reg <= 8'd1;
         else if (cnt_reg != CNT_MAX)
            cnt_reg <= cnt_reg + 8'd1;
         // Only a new column opens a new dwell; a data change just restarts the count.
         if (curr_col != prev_col_reg)
            sampled_reg <= 1'b0;
         else if (sample_pulse)
            sampled_reg <= 1'b1;
      end
   end
endmodule

// File: rtl/matrix_frame_capture.sv
// Rebuilds 16x16 frames from the column-scan stream, publishing a frame only
// after columns 0..15 were sampled in order and pulsing seq_error otherwise.
module matrix_frame_capture
   import matrix_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int COLS          = MATRIX_COLS,
   parameter int ROWS          = MATRIX_ROWS
) (
   input  logic                   clock,
   input  logic                   reset,
   matrix_frame_capture_if.slave  bus
);
   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);

   state_t                    state_reg, state_next;
   logic [COL_BITS-1:0]       expect_reg, expect_next;
   logic [COLS-1:0][ROWS-1:0] shadow_reg, shadow_next;
   logic [FRAME_BITS-1:0]     frame_reg, frame_next;
   logic                      frame_valid_reg, frame_valid_next;
   logic                      seq_error_reg, seq_error_next;
   logic [7:0]                frame_count_reg, frame_count_next;
   logic                      shadow_we;
   logic                      shadow_clear;

   logic                      sample_pulse;
   logic [COL_BITS-1:0]       sample_col;
   logic [MATRIX_ROWS-1:0]    sample_data;

   scan_stability_det #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_det (
      .clock        (clock),
      .reset        (reset),
      .curr_col     (bus.curr_col),
      .data_col     (bus.data_col),
      .sample_pulse (sample_pulse),
      .sample_col   (sample_col),
      .sample_data  (sample_data)
   );

   always_comb begin
      state_next       = state_reg;
      expect_next      = expect_reg;
      frame_next       = frame_reg;
      frame_valid_next = 1'b0;
      seq_error_next   = 1'b0;
      frame_count_next = frame_count_reg;
      shadow_we        = 1'b0;
      shadow_clear     = 1'b0;
      if (sample_pulse) begin
         case (state_reg)
            SYNC: begin
               if (sample_col == '0) begin
                  shadow_we   = 1'b1;
                  expect_next = COL_BITS'(1);
                  state_next  = CAPTURE;
               end
            end
            CAPTURE: begin
               if (sample_col == expect_reg) begin
                  shadow_we   = 1'b1;
                  expect_next = expect_reg + COL_BITS'(1);
                  if (expect_reg == LAST_COL) begin
                     // Last column goes straight into the frame, not via the shadow.
                     frame_next       = {sample_data, shadow_reg[COLS-2:0]};
                     frame_valid_next = 1'b1;
                     frame_count_next = frame_count_reg + 8'd1;
                  end
               end else begin
                  seq_error_next = 1'b1;
                  shadow_clear   = 1'b1;
                  if (sample_col == '0) begin
                     shadow_we   = 1'b1;
                     expect_next = COL_BITS'(1);
                  end else begin
                     state_next  = SYNC;
                     expect_next = '0;
                  end
               end
            end
            default: state_next = SYNC;
         endcase
      end
   end

   for (genvar gi = 0; gi < COLS; gi++) begin : g_shadow
      assign shadow_next[gi] = (shadow_we && sample_col == COL_BITS'(gi)) ? sample_data :
                               shadow_clear                               ? '0          :
                                                                            shadow_reg[gi];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= SYNC;
         expect_reg      <= '0;
         shadow_reg      <= '0;
         frame_reg       <= '0;
         frame_valid_reg <= 1'b0;
         seq_error_reg   <= 1'b0;
         frame_count_reg <= '0;
      end else begin
         state_reg       <= state_next;
         expect_reg      <= expect_next;
         shadow_reg      <= shadow_next;
         frame_reg       <= frame_next;
         frame_valid_reg <= frame_valid_next;
         seq_error_reg   <= seq_error_next;
         frame_count_reg <= frame_count_next;
      end
   end

   assign bus.frame       = frame_reg;
   assign bus.frame_valid = frame_valid_reg;
   assign bus.seq_error   = seq_error_reg;
   assign bus.locked      = (state_reg == CAPTURE);
   assign bus.frame_count = frame_count_reg;
endmodule

// File: tb/tb_matrix_frame_capture.sv
// Directed, table-driven bench: each record is one column dwell with its expected pulses and state.
module tb_matrix_frame_capture;
   logic clock;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   both_cnt = 0;

   matrix_frame_capture_if mif ();

   matrix_frame_capture #(
      .STABLE_CYCLES(4)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (mif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]   col;
      logic [15:0]  data;
      int           len;
      int           fv_at;
      int           se_at;
      int           lk_at;
      bit           lk_end;
      logic [7:0]   cnt;
      logic [255:0] frame;
      bit           rst;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] pat(input int p, input int c);
      logic [15:0] one;
      one = 16'h0001;
      case (p)
         1:       return one << c;
         2:       return 16'h8000 >> c;
         default: return {4'(c), ~(4'(c)), 8'hC3};
      endcase
   endfunction

   function automatic logic [255:0] frame_of(input int p);
      logic [255:0] f;
      f = '0;
      for (int c = 0; c < 16; c++) f[c*16 +: 16] = pat(p, c);
      return f;
   endfunction

   task automatic add(input int col, input logic [15:0] data, input int len,
                      input int fv_at, input int se_at, input int lk_at, input bit lk_end,
                      input int cnt, input logic [255:0] fr, input bit rst);
      vec_t v;
      v.col = 4'(col); v.data = data; v.len = len; v.fv_at = fv_at; v.se_at = se_at;
      v.lk_at = lk_at; v.lk_end = lk_end; v.cnt = 8'(cnt); v.frame = fr; v.rst = rst;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic run_dwell(input logic [3:0] col, input logic [15:0] data, input int len,
                            output int fv_n, output int fv_pos, output int se_n,
                            output int se_pos, output int lk_pos);
      fv_n = 0; fv_pos = 0; se_n = 0; se_pos = 0; lk_pos = 0;
      for (int i = 1; i <= len; i++) begin
         mif.curr_col = col;
         mif.data_col = data;
         @(posedge clock);
         #1;
         if (mif.frame_valid) begin fv_n++; fv_pos = i; end
         if (mif.seq_error) begin se_n++; se_pos = i; end
         if (mif.frame_valid && mif.seq_error) both_cnt++;
         if (mif.locked && lk_pos == 0) lk_pos = i;
      end
   endtask

   initial begin
      logic [255:0] f1, f2, f3, ft;
      int fv_n, fv_pos, se_n, se_pos, lk_pos, fv_tot, se_tot;

      reset = 1'b1;
      mif.curr_col = '0;
      mif.data_col = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_frame", -1, mif.frame, '0);
      chk("rst_frame_valid", -1, 256'(mif.frame_valid), '0);
      chk("rst_seq_error", -1, 256'(mif.seq_error), '0);
      chk("rst_locked", -1, 256'(mif.locked), '0);
      chk("rst_frame_count", -1, 256'(mif.frame_count), '0);
      reset = 1'b0;

      f1 = frame_of(1);
      f2 = frame_of(2);
      f3 = frame_of(3);
      ft = f1;
      ft[255:240] = 16'hBEEF;

      // Clean diagonal scan from reset.
      for (int c = 0; c < 16; c++)
         add(c, pat(1, c), 8, c == 15 ? 4 : 0, 0, c == 0 ? 4 : 1, 1, c == 15 ? 1 : 0, c == 15 ? f1 : '0, 0);
      // Reset, start mid-scan at col 7, then two full scans.
      for (int c = 7; c < 16; c++)
         add(c, pat(2, c), 8, 0, 0, 0, 0, 0, '0, c == 7);
      for (int c = 0; c < 16; c++)
         add(c, pat(2, c), 8, c == 15 ? 4 : 0, 0, c == 0 ? 4 : 1, 1, c == 15 ? 1 : 0, c == 15 ? f2 : '0, 0);
      for (int c = 0; c < 16; c++)
         add(c, pat(3, c), 8, c == 15 ? 4 : 0, 0, 1, 1, c == 15 ? 2 : 1, c == 15 ? f3 : f2, 0);
      // Skip column 5, fall to SYNC, relock at col 0.
      for (int c = 0; c < 5; c++) add(c, pat(1, c), 8, 0, 0, 1, 1, 2, f3, 0);
      add(6, pat(1, 6), 8, 0, 4, 1, 0, 2, f3, 0);
      for (int c = 7; c < 16; c++) add(c, pat(1, c), 8, 0, 0, 0, 0, 2, f3, 0);
      for (int c = 0; c < 16; c++)
         add(c, pat(1, c), 8, c == 15 ? 4 : 0, 0, c == 0 ? 4 : 1, 1, c == 15 ? 3 : 2, c == 15 ? f1 : f3, 0);
      // Glitch: col 3 dwells only 2 cycles, error lands on col 4.
      for (int c = 0; c < 3; c++) add(c, pat(2, c), 8, 0, 0, 1, 1, 3, f1, 0);
      add(3, pat(2, 3), 2, 0, 0, 1, 1, 3, f1, 0);
      add(4, pat(2, 4), 8, 0, 4, 1, 0, 3, f1, 0);
      for (int c = 5; c < 16; c++) add(c, pat(2, c), 8, 0, 0, 0, 0, 3, f1, 0);
      // Out-of-order col 0 while locked: immediate resync, stays locked.
      for (int c = 0; c < 4; c++) add(c, pat(3, c), 8, 0, 0, c == 0 ? 4 : 1, 1, 3, f1, 0);
      add(0, pat(3, 0), 8, 0, 4, 1, 1, 3, f1, 0);
      for (int c = 1; c < 16; c++)
         add(c, pat(3, c), 8, c == 15 ? 4 : 0, 0, 1, 1, c == 15 ? 4 : 3, c == 15 ? f3 : f1, 0);
      // Data toggles inside col 15's dwell: before the sample, then again after it.
      for (int c = 0; c < 15; c++) add(c, pat(1, c), 8, 0, 0, 1, 1, 4, f3, 0);
      add(15, 16'h1234, 2, 0, 0, 1, 1, 4, f3, 0);
      add(15, 16'hBEEF, 6, 4, 0, 1, 1, 5, ft, 0);
      add(15, 16'h0F0F, 4, 0, 0, 1, 1, 5, ft, 0);

      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         run_dwell(vecs[i].col, vecs[i].data, vecs[i].len, fv_n, fv_pos, se_n, se_pos, lk_pos);
         $display("vec %0d col=%0d data=%h len=%0d fv=%0d@%0d se=%0d@%0d lk=%0d cnt=%0d",
                  i, vecs[i].col, vecs[i].data, vecs[i].len, fv_n, fv_pos, se_n, se_pos,
                  mif.locked, mif.frame_count);
         chk("fv_count", i, 256'(fv_n), 256'(vecs[i].fv_at != 0 ? 1 : 0));
         chk("fv_pos", i, 256'(fv_pos), 256'(vecs[i].fv_at));
         chk("se_count", i, 256'(se_n), 256'(vecs[i].se_at != 0 ? 1 : 0));
         chk("se_pos", i, 256'(se_pos), 256'(vecs[i].se_at));
         chk("lk_rise", i, 256'(lk_pos), 256'(vecs[i].lk_at));
         chk("lk_end", i, 256'(mif.locked), 256'(vecs[i].lk_end));
         chk("frame_count", i, 256'(mif.frame_count), 256'(vecs[i].cnt));
         chk("frame", i, mif.frame, vecs[i].frame);
      end

      // Reset asserted during col 9, released during col 10.
      for (int c = 0; c < 9; c++) run_dwell(4'(c), pat(2, c), 8, fv_n, fv_pos, se_n, se_pos, lk_pos);
      run_dwell(4'd9, pat(2, 9), 3, fv_n, fv_pos, se_n, se_pos, lk_pos);
      reset = 1'b1;
      run_dwell(4'd9, pat(2, 9), 3, fv_n, fv_pos, se_n, se_pos, lk_pos);
      $display("midreset col=9 frame_count=%0d locked=%0d", mif.frame_count, mif.locked);
      chk("midrst_frame", 200, mif.frame, '0);
      chk("midrst_count", 200, 256'(mif.frame_count), '0);
      chk("midrst_locked", 200, 256'(mif.locked), '0);
      run_dwell(4'd10, pat(2, 10), 2, fv_n, fv_pos, se_n, se_pos, lk_pos);
      reset = 1'b0;
      fv_tot = 0; se_tot = 0;
      run_dwell(4'd10, pat(2, 10), 6, fv_n, fv_pos, se_n, se_pos, lk_pos);
      fv_tot += fv_n; se_tot += se_n;
      for (int c = 11; c < 16; c++) begin
         run_dwell(4'(c), pat(2, c), 8, fv_n, fv_pos, se_n, se_pos, lk_pos);
         fv_tot += fv_n; se_tot += se_n;
      end
      $display("postreset cols 10..15 fv=%0d se=%0d locked=%0d", fv_tot, se_tot, mif.locked);
      chk("postrst_fv", 201, 256'(fv_tot), '0);
      chk("postrst_se", 201, 256'(se_tot), '0);
      chk("postrst_locked", 201, 256'(mif.locked), '0);
      chk("postrst_frame", 201, mif.frame, '0);
      fv_tot = 0; se_tot = 0;
      for (int c = 0; c < 16; c++) begin
         run_dwell(4'(c), pat(2, c), 8, fv_n, fv_pos, se_n, se_pos, lk_pos);
         fv_tot += fv_n; se_tot += se_n;
      end
      $display("rescan fv=%0d se=%0d count=%0d locked=%0d", fv_tot, se_tot, mif.frame_count, mif.locked);
      chk("rescan_fv", 202, 256'(fv_tot), 256'(1));
      chk("rescan_se", 202, 256'(se_tot), '0);
      chk("rescan_count", 202, 256'(mif.frame_count), 256'(1));
      chk("rescan_locked", 202, 256'(mif.locked), 256'(1));
      chk("rescan_frame", 202, mif.frame, f2);
      chk("fv_se_exclusive", 203, 256'(both_cnt), '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
